// File: rtl/ram_reader_pkg.sv
// Shared types and constants for the RAM stream reader.
// Holds the sequencer state enum and the FIFO/credit sizing.
package ram_reader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      FINISH
   } state_t;

   localparam int FIFO_DEPTH = 4;
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CREDIT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CREDIT_W-1:0] DEPTH_C = CREDIT_W'(FIFO_DEPTH);

endpackage

// File: rtl/ram_stream_reader_if.sv
// Bundle of command, RAM read-port and stream signals of the reader.
// slave = reader side, master = controller/RAM/sink side.
// Option RAM_READER_STALL_CNT_EN adds stallCount.
interface ram_stream_reader_if #(
   parameter int AW = 9,
   parameter int DW = 32
);
   logic          start;
   logic [AW-1:0] baseAddress;
   logic [AW:0]   burstLength;
   logic          busy;
   logic          done;
   logic [AW-1:0] ramAddress;
   logic [DW-1:0] ramData;
   logic [DW-1:0] streamData;
   logic          streamValid;
   logic          streamReady;
   logic          streamLast;
`ifdef RAM_READER_STALL_CNT_EN
   logic [31:0]   stallCount;
`endif

   modport slave (
      input  start, baseAddress, burstLength,
      input  ramData, streamReady,
      output busy, done, ramAddress,
      output streamData, streamValid, streamLast
`ifdef RAM_READER_STALL_CNT_EN
      , output stallCount
`endif
   );

   modport master (
      output start, baseAddress, burstLength,
      output ramData, streamReady,
      input  busy, done, ramAddress,
      input  streamData, streamValid, streamLast
`ifdef RAM_READER_STALL_CNT_EN
      , input stallCount
`endif
   );

endinterface

// File: rtl/reader_skid_fifo.sv
// 4-entry synchronous FIFO of {last, data} words.
// Ports: push/pushData, pop/popData (head), valid, count.
module reader_skid_fifo
   import ram_reader_pkg::*;
#(
   parameter int W = 33
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                i_push,
   input  logic [W-1:0]        i_pushData,
   input  logic                i_pop,
   output logic [W-1:0]        o_popData,
   output logic                o_valid,
   output logic [CREDIT_W-1:0] o_count
);

   logic [W-1:0]        r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wrPtr;
   logic [PTR_W-1:0]    r_rdPtr;
   logic [CREDIT_W-1:0] r_count;
   logic                w_pop;

   assign w_pop     = i_pop && (r_count != '0);
   assign o_valid   = (r_count != '0);
   assign o_count   = r_count;
   assign o_popData = r_mem[r_rdPtr];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wrPtr] <= i_pushData;
            r_wrPtr        <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({i_push, w_pop})
            2'b10:   r_count <= r_count + CREDIT_W'(1);
            2'b01:   r_count <= r_count - CREDIT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/ram_stream_reader.sv
// Burst read sequencer: issues RAM read addresses, turns read data into a stream.
// Ports: clock, reset, bus (slave). Option RAM_READER_STALL_CNT_EN adds stallCount.
module ram_stream_reader
   import ram_reader_pkg::*;
#(
   parameter int nrOfEntries = 512,
   parameter int entryLength = 32
) (
   input logic                clock,
   input logic                reset,
   ram_stream_reader_if.slave bus
);

   localparam int AW = $clog2(nrOfEntries);

   state_t              r_state;
   state_t              w_nextState;
   logic [AW-1:0]       r_nextAddr;
   logic [AW-1:0]       r_ramAddress;
   logic [AW:0]         r_len;
   logic [AW:0]         r_issueCnt;
   logic                r_tag0, r_tag1;
   logic                r_last0, r_last1;
   logic                w_accept;
   logic                w_issue;
   logic                w_lastIssue;
   logic                w_pop;
   logic                w_fifoValid;
   logic [entryLength:0] w_head;
   logic [CREDIT_W-1:0] w_count;
   logic [CREDIT_W-1:0] w_used;
   logic [AW-1:0]       w_addrInc;

   // Words already owed to the FIFO: stored plus both in-flight stages.
   assign w_used = w_count + CREDIT_W'(r_tag0) + CREDIT_W'(r_tag1);
   assign w_issue = (r_state == ISSUE) && (w_used < DEPTH_C);
   assign w_lastIssue = w_issue && (r_issueCnt == r_len - (AW+1)'(1));
   assign w_pop = w_fifoValid && bus.streamReady;
   assign w_addrInc = (r_nextAddr == AW'(nrOfEntries - 1)) ?
                      '0 : r_nextAddr + AW'(1);

   always_comb begin
      w_nextState = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_accept    = 1'b1;
               w_nextState = (bus.burstLength == '0) ? FINISH : ISSUE;
            end
         end
         ISSUE:   if (w_lastIssue) w_nextState = DRAIN;
         DRAIN:   if (w_pop && w_head[entryLength]) w_nextState = FINISH;
         FINISH:  w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_nextAddr   <= '0;
         r_ramAddress <= '0;
         r_len        <= '0;
         r_issueCnt   <= '0;
         r_tag0       <= 1'b0;
         r_tag1       <= 1'b0;
         r_last0      <= 1'b0;
         r_last1      <= 1'b0;
      end else begin
         r_state <= w_nextState;
         if (w_accept) begin
            r_nextAddr <= bus.baseAddress;
            r_len      <= bus.burstLength;
            r_issueCnt <= '0;
         end else if (w_issue) begin
            r_ramAddress <= r_nextAddr;
            r_nextAddr   <= w_addrInc;
            r_issueCnt   <= r_issueCnt + (AW+1)'(1);
         end
         // Tag pipe tracks which ramData cycles carry requested words.
         r_tag0  <= w_issue;
         r_last0 <= w_lastIssue;
         r_tag1  <= r_tag0;
         r_last1 <= r_last0;
      end
   end

   reader_skid_fifo #(.W(entryLength + 1)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .i_push     (r_tag1),
      .i_pushData ({r_last1, bus.ramData}),
      .i_pop      (w_pop),
      .o_popData  (w_head),
      .o_valid    (w_fifoValid),
      .o_count    (w_count)
   );

   assign bus.busy        = (r_state != IDLE);
   assign bus.done        = (r_state == FINISH);
   assign bus.ramAddress  = r_ramAddress;
   assign bus.streamValid = w_fifoValid;
   assign bus.streamData  = w_head[entryLength-1:0];
   assign bus.streamLast  = w_fifoValid && w_head[entryLength];

`ifdef RAM_READER_STALL_CNT_EN
   logic [31:0] r_stallCount;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stallCount <= '0;
      end else if (w_accept) begin
         r_stallCount <= '0;
      end else if (w_fifoValid && !bus.streamReady &&
                   (r_stallCount != 32'hFFFF_FFFF)) begin
         r_stallCount <= r_stallCount + 32'd1;
      end
   end

   assign bus.stallCount = r_stallCount;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader.
// Table-driven bursts with a scoreboard queue plus reset/stall sequences.
module tb_ram_stream_reader;

   localparam int N      = 512;
   localparam int AW     = 9;
   localparam int DW     = 32;
   localparam int BUDGET = 3000;

   logic clock;
   logic reset;

   ram_stream_reader_if #(.AW(AW), .DW(DW)) bus ();

   ram_stream_reader #(.nrOfEntries(N), .entryLength(DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [31:0] ramVal(input logic [8:0] a);
      return 32'hD00D_0000 ^ {a, 7'h5, ~a, 7'h2A};
   endfunction

   // Read port of the dual-port RAM: one cycle latency.
   always @(posedge clock) bus.ramData <= ramVal(bus.ramAddress);

   typedef struct {
      int base;
      int len;
      int mode;      // 0 ready=1, 1 toggle, 2 random, 3 stall 5 then ready
      bit midStart;
   } vec_t;

   int checks;
   int failures;
   logic [32:0] q[$];

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic nextReady(input int mode, input int t,
                                      input int stalls);
      case (mode)
         0: return 1'b1;
         1: return t[0];
         2: return 1'($urandom_range(0, 1));
         default: return (stalls >= 5);
      endcase
   endfunction

   task automatic run_vec(input vec_t v);
      int t, firstV, lastHs, doneT, stalls;
      logic pv;
      logic [32:0] pd;
      logic [32:0] exp;
      bit fin;
      for (int i = 0; i < v.len; i++) begin
         q.push_back({1'(i == v.len - 1), ramVal(9'((v.base + i) % N))});
      end
      bus.baseAddress = 9'(v.base);
      bus.burstLength = 10'(v.len);
      bus.start = 1'b1;
      bus.streamReady = (v.mode == 0 || v.mode == 1) ? 1'b1 : 1'b0;
      if (v.mode == 2) bus.streamReady = 1'($urandom_range(0, 1));
      @(negedge clock);
      bus.start = 1'b0;
      t = 0; firstV = -1; lastHs = -1; doneT = -1;
      stalls = 0; pv = 1'b0; pd = '0; fin = 1'b0;
      while (t < BUDGET && !fin) begin
`ifdef RAM_READER_STALL_CNT_EN
         if (t == 0) chk("stall_clear", 64'(bus.stallCount), 64'd0);
`endif
         chk("busy_high", 64'(bus.busy), 64'd1);
         if (pv) begin
            chk("stable_valid", 64'(bus.streamValid), 64'd1);
            chk("stable_word", 64'({bus.streamLast, bus.streamData}),
                64'(pd));
         end
         if (bus.streamValid) begin
            if (firstV < 0) firstV = t;
            if (bus.streamReady) begin
               if (q.size() == 0) begin
                  chk("extra_beat", 64'(bus.streamData), 64'hDEAD);
               end else begin
                  exp = q.pop_front();
                  chk("beat", 64'({bus.streamLast, bus.streamData}),
                      64'(exp));
               end
               if (bus.streamLast) lastHs = t;
            end else begin
               stalls++;
            end
         end
         pv = bus.streamValid && !bus.streamReady;
         pd = {bus.streamLast, bus.streamData};
         if (bus.done) begin
            doneT = t;
            fin = 1'b1;
         end else begin
            @(posedge clock);
            #1;
            bus.streamReady = nextReady(v.mode, t, stalls);
            if (v.midStart && t == 3) begin
               bus.start = 1'b1;
               bus.baseAddress = 9'd300;
               bus.burstLength = 10'd2;
            end else begin
               bus.start = 1'b0;
            end
            @(negedge clock);
            t++;
         end
      end
      chk("done_seen", 64'(fin), 64'd1);
      if (v.len > 0) begin
         chk("first_valid_lat", 64'(firstV), 64'd3);
         chk("done_after_last", 64'(doneT), 64'(lastHs + 1));
         if (v.mode == 0) chk("no_bubbles", 64'(doneT), 64'(v.len + 3));
      end else begin
         chk("len0_no_valid", 64'(firstV), 64'hFFFF_FFFF_FFFF_FFFF);
         chk("len0_done_lat", 64'(doneT), 64'd0);
      end
      chk("sb_empty", 64'(q.size()), 64'd0);
      q.delete();
`ifdef RAM_READER_STALL_CNT_EN
      chk("stall_count", 64'(bus.stallCount), 64'(stalls));
      if (v.mode == 3) chk("stall_count5", 64'(bus.stallCount), 64'd5);
`endif
      @(negedge clock);
      chk("idle_after", 64'({bus.busy, bus.done, bus.streamValid}), 64'd0);
   endtask

   vec_t vecs[9];
   int hs;
   int tt;
   logic bad;

   initial begin
      checks = 0;
      failures = 0;
      vecs[0] = '{base: 10,  len: 4,   mode: 0, midStart: 1'b0};
      vecs[1] = '{base: 510, len: 4,   mode: 0, midStart: 1'b0};
      vecs[2] = '{base: 20,  len: 8,   mode: 1, midStart: 1'b0};
      vecs[3] = '{base: 7,   len: 0,   mode: 0, midStart: 1'b0};
      vecs[4] = '{base: 100, len: 6,   mode: 0, midStart: 1'b1};
      vecs[5] = '{base: 300, len: 512, mode: 0, midStart: 1'b0};
      vecs[6] = '{base: 3,   len: 4,   mode: 3, midStart: 1'b0};
      vecs[7] = '{base: 400, len: 20,  mode: 2, midStart: 1'b0};
      vecs[8] = '{base: 0,   len: 1,   mode: 1, midStart: 1'b0};

      reset = 1'b1;
      bus.start = 1'b0;
      bus.baseAddress = '0;
      bus.burstLength = '0;
      bus.streamReady = 1'b0;
      repeat (3) @(negedge clock);
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_valid", 64'(bus.streamValid), 64'd0);
      chk("rst_last", 64'(bus.streamLast), 64'd0);
      chk("rst_data", 64'(bus.streamData), 64'd0);
      chk("rst_addr", 64'(bus.ramAddress), 64'd0);
      reset = 1'b0;
      @(negedge clock);

      for (int i = 0; i < 9; i++) run_vec(vecs[i]);

      // Reset in the middle of a burst, after the third beat.
      bus.baseAddress = 9'd50;
      bus.burstLength = 10'd8;
      bus.streamReady = 1'b1;
      bus.start = 1'b1;
      @(negedge clock);
      bus.start = 1'b0;
      hs = 0;
      tt = 0;
      while (hs < 3 && tt < 50) begin
         if (bus.streamValid && bus.streamReady) hs++;
         if (hs < 3) begin
            @(negedge clock);
            tt++;
         end
      end
      chk("rst_mid_reach", 64'(hs), 64'd3);
      @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("rstmid_outs", 64'({bus.busy, bus.done, bus.streamValid,
                             bus.streamLast}), 64'd0);
      chk("rstmid_data", 64'(bus.streamData), 64'd0);
      chk("rstmid_addr", 64'(bus.ramAddress), 64'd0);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clock);
         bad = bad | bus.streamValid | bus.done | bus.busy;
      end
      chk("rstmid_quiet", 64'(bad), 64'd0);

      run_vec(vecs[0]);
      run_vec(vecs[1]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
